// File: rtl/hog_bank_wr_arbiter.sv
// Bank write-port arbiter between the HOG result writer and host load path, with a per-bank
// one-entry skid register, a multi-mode test pixel generator and a host-stall counter.
module hog_bank_wr_arbiter #(
  parameter int unsigned          N_BANKS    = 4,
  parameter int unsigned          RAM_AW     = 17,
  parameter int unsigned          QN         = 10,
  parameter int unsigned          P_WIDTH    = 8,
  parameter int unsigned          RAMP_BITS  = 5,
  parameter logic [P_WIDTH-1:0]   TEST_CONST = P_WIDTH'(128)
) (
  input  logic                        aclk,
  input  logic                        rst,
  // result writer
  input  logic [N_BANKS-1:0]          res_en,
  input  logic [N_BANKS-1:0]          res_we,
  input  logic [N_BANKS*RAM_AW-1:0]   res_addr,
  input  logic [N_BANKS*QN-1:0]       res_din,
  // host initial-load path
  input  logic [N_BANKS-1:0]          host_en,
  input  logic [N_BANKS-1:0]          host_we,
  input  logic [N_BANKS*RAM_AW-1:0]   host_addr,
  input  logic [N_BANKS*P_WIDTH-1:0]  host_din,
  output logic [N_BANKS-1:0]          host_ready,
  // arbitrated bank ports
  output logic [N_BANKS-1:0]          bram_en,
  output logic [N_BANKS-1:0]          bram_we,
  output logic [N_BANKS*RAM_AW-1:0]   bram_addr,
  output logic [N_BANKS*QN-1:0]       bram_din,
  // pixel stream into hog_top
  input  logic [1:0]                  test_mode,
  input  logic [P_WIDTH-1:0]          p_in,
  input  logic                        p_valid_in,
  input  logic                        frame_done,
  output logic [P_WIDTH-1:0]          p_out,
  output logic                        p_valid_out,
  // statistics
  input  logic                        clr_stats,
  output logic [15:0]                 stall_cnt
);

  logic [N_BANKS-1:0]          hold_valid_q, hold_valid_d;
  logic [N_BANKS-1:0]          hold_we_q, hold_we_d;
  logic [N_BANKS*RAM_AW-1:0]   hold_addr_q, hold_addr_d;
  logic [N_BANKS*P_WIDTH-1:0]  hold_din_q, hold_din_d;

  logic [N_BANKS-1:0]          host_acc;
  logic [N_BANKS-1:0]          host_stall;
  logic                        any_stall;

  logic [15:0]                 stall_q, stall_d;
  logic [RAMP_BITS-1:0]        ramp_q, ramp_d;
  logic [P_WIDTH-1:0]          p_q, p_d;
  logic                        p_valid_q;

  assign host_ready = ~hold_valid_q;
  assign host_acc   = host_en & host_ready;
  assign host_stall = host_en & ~host_ready;
  assign any_stall  = |host_stall;

  // Later assignments override earlier ones: result > hold > host.
  always_comb begin
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      bram_en[b]                 = host_en[b];
      bram_we[b]                 = host_en[b] & host_we[b];
      bram_addr[b*RAM_AW +: RAM_AW] = host_addr[b*RAM_AW +: RAM_AW];
      bram_din[b*QN +: QN]       = QN'(host_din[b*P_WIDTH +: P_WIDTH]);
      if (hold_valid_q[b]) begin
        bram_en[b]                 = 1'b1;
        bram_we[b]                 = hold_we_q[b];
        bram_addr[b*RAM_AW +: RAM_AW] = hold_addr_q[b*RAM_AW +: RAM_AW];
        bram_din[b*QN +: QN]       = QN'(hold_din_q[b*P_WIDTH +: P_WIDTH]);
      end
      if (res_en[b]) begin
        bram_en[b]                 = 1'b1;
        bram_we[b]                 = res_we[b];
        bram_addr[b*RAM_AW +: RAM_AW] = res_addr[b*RAM_AW +: RAM_AW];
        bram_din[b*QN +: QN]       = res_din[b*QN +: QN];
      end
    end
  end

  // An accepted access only needs parking when the result writer owns the port.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_din_d   = hold_din_q;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (host_acc[b] && res_en[b]) begin
        hold_valid_d[b]                 = 1'b1;
        hold_we_d[b]                    = host_we[b];
        hold_addr_d[b*RAM_AW +: RAM_AW] = host_addr[b*RAM_AW +: RAM_AW];
        hold_din_d[b*P_WIDTH +: P_WIDTH] = host_din[b*P_WIDTH +: P_WIDTH];
      end else if (hold_valid_q[b] && !res_en[b]) begin
        hold_valid_d[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_we_q    <= '0;
      hold_addr_q  <= '0;
      hold_din_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_din_q   <= hold_din_d;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (any_stall && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

  // Emitted pixel uses the pre-update ramp; frame_done beats a concurrent increment.
  always_comb begin
    ramp_d = ramp_q;
    if (frame_done) begin
      ramp_d = '0;
    end else if (p_valid_in) begin
      ramp_d = ramp_q + RAMP_BITS'(1);
    end
    case (test_mode)
      2'd1:    p_d = P_WIDTH'(ramp_q);
      2'd2:    p_d = TEST_CONST;
      default: p_d = p_in;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      ramp_q    <= '0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      ramp_q    <= ramp_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_in;
    end
  end

  assign p_out       = p_q;
  assign p_valid_out = p_valid_q;

endmodule

// File: tb/tb_hog_bank_wr_arbiter.sv
// Scoreboard bench for hog_bank_wr_arbiter: a per-cycle reference model pushes expected
// outputs; a negedge monitor pops and compares.
module tb_hog_bank_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 17;
  localparam int QN = 10;
  localparam int PW = 8;
  localparam int RAMP_MOD = 32;

  logic              aclk = 1'b0;
  logic              rst;
  logic [N-1:0]      res_en, res_we, host_en, host_we, host_ready;
  logic [N*AW-1:0]   res_addr, host_addr, bram_addr;
  logic [N*QN-1:0]   res_din, bram_din;
  logic [N*PW-1:0]   host_din;
  logic [N-1:0]      bram_en, bram_we;
  logic [1:0]        test_mode;
  logic [PW-1:0]     p_in, p_out;
  logic              p_valid_in, frame_done, p_valid_out, clr_stats;
  logic [15:0]       stall_cnt;

  always #5 aclk = ~aclk;

  hog_bank_wr_arbiter #(
    .N_BANKS(N), .RAM_AW(AW), .QN(QN), .P_WIDTH(PW), .RAMP_BITS(5), .TEST_CONST(8'd128)
  ) dut (
    .aclk(aclk), .rst(rst),
    .res_en(res_en), .res_we(res_we), .res_addr(res_addr), .res_din(res_din),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_ready(host_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .test_mode(test_mode), .p_in(p_in), .p_valid_in(p_valid_in), .frame_done(frame_done),
    .p_out(p_out), .p_valid_out(p_valid_out),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [N-1:0]    en;
    logic [N-1:0]    we;
    logic [N-1:0]    rdy;
    logic [N*AW-1:0] addr;
    logic [N*QN-1:0] din;
    logic [15:0]     stall;
    logic            pv;
    logic [PW-1:0]   p;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: parked host access per bank, stall count, ramp, pixel register.
  bit            mh_v[N];
  logic          mh_we[N];
  logic [AW-1:0] mh_addr[N];
  logic [PW-1:0] mh_din[N];
  int            m_stall;
  int            m_ramp;
  logic          m_pv;
  logic [PW-1:0] m_p;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < N; b++) mh_v[b] = 1'b0;
    m_stall = 0;
    m_ramp  = 0;
    m_pv    = 1'b0;
    m_p     = '0;
  endtask

  task automatic clear_inputs();
    res_en = '0; res_we = '0; res_addr = '0; res_din = '0;
    host_en = '0; host_we = '0; host_addr = '0; host_din = '0;
    test_mode = 2'd0; p_in = '0; p_valid_in = 1'b0; frame_done = 1'b0; clr_stats = 1'b0;
  endtask

  // Predict this cycle's outputs, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    bit   any;
    e = '0;
    for (int b = 0; b < N; b++) begin
      e.rdy[b] = !mh_v[b];
      if (res_en[b]) begin
        e.en[b] = 1'b1; e.we[b] = res_we[b];
        e.addr[b*AW +: AW] = res_addr[b*AW +: AW];
        e.din[b*QN +: QN]  = res_din[b*QN +: QN];
      end else if (mh_v[b]) begin
        e.en[b] = 1'b1; e.we[b] = mh_we[b];
        e.addr[b*AW +: AW] = mh_addr[b];
        e.din[b*QN +: QN]  = QN'(mh_din[b]);
      end else if (host_en[b]) begin
        e.en[b] = 1'b1; e.we[b] = host_we[b];
        e.addr[b*AW +: AW] = host_addr[b*AW +: AW];
        e.din[b*QN +: QN]  = QN'(host_din[b*PW +: PW]);
      end
    end
    e.stall = 16'(m_stall);
    e.pv    = m_pv;
    e.p     = m_p;
    sb.push_back(e);

    any = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (host_en[b] && mh_v[b]) any = 1'b1;
      if (host_en[b] && !mh_v[b] && res_en[b]) begin
        mh_v[b] = 1'b1; mh_we[b] = host_we[b];
        mh_addr[b] = host_addr[b*AW +: AW];
        mh_din[b]  = host_din[b*PW +: PW];
      end else if (mh_v[b] && !res_en[b]) begin
        mh_v[b] = 1'b0;
      end
    end
    if (clr_stats) m_stall = 0;
    else if (any && m_stall < 65535) m_stall = m_stall + 1;
    m_pv = p_valid_in;
    if (test_mode == 2'd1)      m_p = PW'(m_ramp);
    else if (test_mode == 2'd2) m_p = 8'd128;
    else                        m_p = p_in;
    if (frame_done)      m_ramp = 0;
    else if (p_valid_in) m_ramp = (m_ramp + 1) % RAMP_MOD;
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("host_ready", 64'(host_ready), 64'(e.rdy));
      chk("bram_en", 64'(bram_en), 64'(e.en));
      chk("bram_we", 64'(bram_we), 64'(e.we));
      for (int b = 0; b < N; b++) begin
        if (e.en[b]) begin
          chk($sformatf("bram_addr[%0d]", b), 64'(bram_addr[b*AW +: AW]), 64'(e.addr[b*AW +: AW]));
          chk($sformatf("bram_din[%0d]", b), 64'(bram_din[b*QN +: QN]), 64'(e.din[b*QN +: QN]));
        end
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
      chk("p_valid_out", 64'(p_valid_out), 64'(e.pv));
      if (e.pv) chk("p_out", 64'(p_out), 64'(e.p));
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;

    // Pass-through on bank 0.
    host_en[0] = 1'b1; host_we[0] = 1'b1;
    host_addr[0 +: AW] = 17'h00010; host_din[0 +: PW] = 8'hA5;
    step();
    clear_inputs();
    step();

    // Collision on bank 2: host parks behind a 3-cycle result burst.
    res_en[2] = 1'b1; res_we[2] = 1'b1;
    res_addr[2*AW +: AW] = 17'h00100; res_din[2*QN +: QN] = 10'h3FF;
    host_en[2] = 1'b1; host_we[2] = 1'b1;
    host_addr[2*AW +: AW] = 17'h00200; host_din[2*PW +: PW] = 8'h11;
    step();
    host_addr[2*AW +: AW] = 17'h00204; host_din[2*PW +: PW] = 8'h22;
    step();
    host_en[2] = 1'b0;
    step();
    res_en[2] = 1'b0;
    step();
    step();
    clear_inputs();

    // Independent banks.
    res_en = 4'b0101; res_we = 4'b0101;
    for (int b = 0; b < N; b++) begin
      res_addr[b*AW +: AW]  = AW'(17'h1000 + b);
      res_din[b*QN +: QN]   = QN'(10'h200 + b);
      host_addr[b*AW +: AW] = AW'(17'h0040 + b);
      host_din[b*PW +: PW]  = PW'(8'h30 + b);
    end
    host_en = 4'b1010; host_we = 4'b1010;
    step();
    clear_inputs();
    step();

    // Ramp: 40 valids, then a frame_done on the 10th valid of a second run.
    test_mode = 2'd1;
    p_valid_in = 1'b1;
    for (int i = 0; i < 40; i++) step();
    p_valid_in = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      p_valid_in = 1'b1;
      frame_done = (i == 9);
      step();
    end
    clear_inputs();
    step();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      res_en  = 4'($urandom) & 4'($urandom);
      res_we  = 4'($urandom);
      host_en = 4'($urandom);
      host_we = 4'($urandom);
      for (int b = 0; b < N; b++) begin
        res_addr[b*AW +: AW]  = AW'($urandom);
        res_din[b*QN +: QN]   = QN'($urandom);
        host_addr[b*AW +: AW] = AW'($urandom);
        host_din[b*PW +: PW]  = PW'($urandom);
      end
      test_mode  = 2'($urandom);
      p_in       = PW'($urandom);
      p_valid_in = 1'($urandom);
      frame_done = ($urandom_range(0, 19) == 0);
      clr_stats  = ($urandom_range(0, 49) == 0);
      step();
    end
    clear_inputs();
    step();

    // Reset in the middle of a parked access on bank 1.
    res_en[1] = 1'b1; res_we[1] = 1'b1;
    host_en[1] = 1'b1; host_we[1] = 1'b1;
    host_addr[1*AW +: AW] = 17'h0ABCD; host_din[1*PW +: PW] = 8'h5A;
    test_mode = 2'd2; p_valid_in = 1'b1;
    step();
    step();
    rst = 1'b1;
    model_reset();
    clear_inputs();
    @(posedge aclk);
    #1 rst = 1'b0;
    step();
    step();

    // Saturation of the stall counter, then clear during a stall.
    res_en[3] = 1'b1; res_we[3] = 1'b1;
    host_en[3] = 1'b1; host_we[3] = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    chk("stall_saturated", 64'(stall_cnt), 64'h0000_0000_0000_FFFF);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    step();
    clear_inputs();
    step();
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge aclk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hog_bank_wr_arbiter.md
Name: hog_bank_wr_arbiter

Overview:
- Parametrised successor to the imagescaling/HOG top-level bank glue.
- Arbitrates N_BANKS BRAM write ports between the HOG result writer and the host initial-load path. The result writer always has priority.
- Blocked host accesses are held in a one-entry skid register per bank and retire later, so none are lost. The existing design drops them silently.
- Also contains a registered, multi-mode test pixel generator on the p/p_valid stream into hog_top, plus a saturating host-stall statistics counter.

Parameters:
- N_BANKS, 4, number of BRAM banks.
- RAM_AW, 17, bank address width.
- QN, 10, bank data width.
- P_WIDTH, 8, host/pixel data width; P_WIDTH <= QN.
- RAMP_BITS, 5, ramp pattern wraps modulo 2^RAMP_BITS.
- TEST_CONST, 8'd128, constant-mode pixel value.

Ports:
- aclk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- res_en  in  N_BANKS  result-writer enable per bank.
- res_we  in  N_BANKS  result-writer write enable.
- res_addr  in  N_BANKS*RAM_AW  result address; bank b occupies bits [b*RAM_AW +: RAM_AW].
- res_din  in  N_BANKS*QN  result data.
- host_en  in  N_BANKS  host access request.
- host_we  in  N_BANKS  host write enable.
- host_addr  in  N_BANKS*RAM_AW  host address.
- host_din  in  N_BANKS*P_WIDTH  host data.
- host_ready  out  N_BANKS  host access accepted this cycle when high.
- bram_en  out  N_BANKS  arbitrated bank enable.
- bram_we  out  N_BANKS  arbitrated bank write enable.
- bram_addr  out  N_BANKS*RAM_AW  arbitrated bank address.
- bram_din  out  N_BANKS*QN  arbitrated bank data.
- test_mode  in  2  pattern select: 0 pass, 1 ramp, 2 constant, 3 pass.
- p_in  in  P_WIDTH  scaler pixel.
- p_valid_in  in  1  scaler pixel valid.
- frame_done  in  1  scaling finished pulse.
- p_out  out  P_WIDTH  pixel to HOG.
- p_valid_out  out  1  pixel valid to HOG.
- clr_stats  in  1  synchronous clear of the stall counter.
- stall_cnt  out  16  saturating host-stall cycle count.

Behaviour:
- Reset (async, rst=1):
  - hold_valid[*]=0 and any held write is discarded.
  - ramp=0, p_out=0, p_valid_out=0, stall_cnt=0.
  - host_ready=all ones once rst deasserts. bram_* follow the combinational rules below.
- Per-bank arbitration is combinational, with zero latency on the bram_* outputs. Priority order:
  1. res_en[b]: bram_en=1, and we/addr/din come from the res_* inputs.
  2. Otherwise hold_valid[b]: bram_en=1, and we/addr/din come from the hold register.
  3. Otherwise host_en[b]: bram_en=1, and we/addr/din come from the host_* inputs.
  4. Otherwise bram_en=0, bram_we=0; bram_addr/din don't-care, driven with the host values.
- Host data is always zero-extended from P_WIDTH to QN.
- Hold register and handshake:
  - host_ready[b] = ~hold_valid[b].
  - An access is accepted when host_en[b] & host_ready[b].
  - Accepted while res_en[b]=1: captured into hold on the clock edge, hold_valid[b] set. Applies to both reads and writes.
  - Accepted while res_en[b]=0: passes straight through, no capture.
  - Hold drains in the first cycle with res_en[b]=0. hold_valid[b] clears on that edge, so host_ready rises the next cycle.
  - While res_en stays high the hold persists indefinitely.
  - Simultaneous drain and new host request cannot occur, because host_ready=0 while hold is valid.
- Stall counter:
  - Increments by 1 in each cycle where any bank has host_en & ~host_ready. Several banks stalled in one cycle still count as 1.
  - Saturates at 16'hFFFF.
  - clr_stats wins over increment in the same cycle.
- Pixel path, 1-cycle registered latency:
  - p_valid_out <= p_valid_in.
  - p_out <= selected value:
    - mode 0/3: p_in.
    - mode 1: zero-extended ramp.
    - mode 2: TEST_CONST.
  - Ramp is a RAMP_BITS counter: it increments on p_valid_in and wraps from 2^RAMP_BITS-1 to 0.
  - The ramp value emitted with a valid is the pre-increment value.
  - frame_done forces ramp to 0 and overrides a simultaneous p_valid_in increment. The pixel emitted that cycle still uses the pre-clear value.
  - test_mode may change at any time and takes effect on the next registered pixel.

Test Plan:
- Reset: assert rst mid-hold (bank1 hold_valid=1) -> host_ready=4'hF after release, held write never appears on bram_en[1], stall_cnt=0, p_out=0.
- Pass-through: host_en[0]=1, we=1, addr=17'h00010, din=8'hA5, res_en=0 -> same cycle bram_en[0]=1, bram_addr=17'h00010, bram_din=10'h0A5; host_ready[0] stays 1.
- Collision:
  - res_en[2]=1 for 3 cycles with addr=17'h100, din=10'h3FF; host write to bank2 at addr 17'h200, din 8'h11 in the first cycle.
  - Required: result on the port for 3 cycles; host_ready[2]=0 for 3 cycles.
  - Required: cycle 4 bram_addr=17'h200, bram_din=10'h011.
  - Required: host_ready[2]=1 in cycle 5; stall_cnt counts only cycles with host_en held high while blocked.
- Independent banks: res_en=4'b0101 while the host writes banks 1 and 3 -> banks 1 and 3 pass through in the same cycle, banks 0 and 2 carry result data.
- Ramp: test_mode=1, RAMP_BITS=5, 40 consecutive p_valid_in -> p_out sequence 0..31,0..7, each one cycle after its valid. frame_done with the 10th valid -> next valid outputs 0.
- Saturation: preload the counter via 65540 stalled cycles -> stall_cnt=16'hFFFF; clr_stats together with a stall -> 0.
